// File: rtl/fifo_param_flags_pkg.sv
// Shared defaults and helpers for the parametrised lane FIFO.
package fifo_param_flags_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;

    // Number of storage entries addressed by a pointer of the given width.
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// Dual-port storage: synchronous write, registered read. The array itself is
// never reset; only the read-data register is, so data_out starts at zero.
module fifo_ram_dp
    import fifo_param_flags_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write; no reset so it maps onto plain flops/RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; holds its value when no read is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_param_flags.sv
// Lane-buffer FIFO: pointers, occupancy count, decoded flags, sticky errors.
// A read and write in the same cycle while full are both accepted because the
// read frees the slot the write lands in; the RAM read returns the old word.
module fifo_param_flags
    import fifo_param_flags_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int AF_TH  = 3,
    parameter int AE_TH  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic              read,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [ADDR_W:0]   fifo_count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int              CNT_W   = ADDR_W + 1;
    localparam int              DEPTH   = depth_of(ADDR_W);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_TH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_TH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_acc;
    logic              wr_acc;

    // Flags decode straight from the registered count.
    always_comb begin
        full         = (fifo_count == DEPTH_C);
        empty        = (fifo_count == '0);
        almost_full  = (fifo_count >= AF_C);
        almost_empty = (fifo_count <= AE_C);
        rd_acc       = read & ~empty;
        wr_acc       = write & (~full | rd_acc);
    end

    // Pointer advance; ADDR_W-bit pointers wrap on their own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_count <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Read-valid strobe and sticky error flags; errors never gate traffic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            valid_out <= rd_acc;
            if (write && !wr_acc) overflow  <= 1'b1;
            if (read && empty)    underflow <= 1'b1;
        end
    end

    fifo_ram_dp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (data_out)
    );

endmodule

// File: tb/tb_fifo_param_flags.sv
// Directed bench for the 4x8 lane FIFO with AF_TH=3, AE_TH=1.
module tb_fifo_param_flags;

    logic       clk;
    logic       reset;
    logic       write;
    logic       read;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic [2:0] fifo_count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_param_flags #(
        .DATA_W (8),
        .ADDR_W (2),
        .AF_TH  (3),
        .AE_TH  (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write        (write),
        .read         (read),
        .data_in      (data_in),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .fifo_count   (fifo_count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given request; outputs are stable on return (#1 after edge).
    task automatic op(input logic w, input logic r, input logic [7:0] d);
        write   = w;
        read    = r;
        data_in = d;
        @(posedge clk);
        #1;
        write   = 1'b0;
        read    = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input logic [2:0] cnt,
                             input logic f, input logic e, input logic af, input logic ae);
        chk({tag, ".count"}, fifo_count, cnt);
        chk({tag, ".full"}, full, f);
        chk({tag, ".empty"}, empty, e);
        chk({tag, ".afull"}, almost_full, af);
        chk({tag, ".aempty"}, almost_empty, ae);
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("rst.count", fifo_count, 3'd0);
        chk("rst.valid", valid_out, 1'b0);
        chk("rst.ovf", overflow, 1'b0);
        chk("rst.udf", underflow, 1'b0);
        chk("rst.empty", empty, 1'b1);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_d;
        write   = 1'b0;
        read    = 1'b0;
        data_in = 8'h00;
        reset   = 1'b1;
        #1;
        reset   = 1'b0;
        #1;
        // Reset state, checked before any clock edge.
        chk_flags("init", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("init.dout", data_out, 8'h00);
        chk("init.valid", valid_out, 1'b0);
        chk("init.ovf", overflow, 1'b0);
        chk("init.udf", underflow, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Fill.
        op(1'b1, 1'b0, 8'hA1); chk_flags("fill1", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        op(1'b1, 1'b0, 8'hA2); chk_flags("fill2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        op(1'b1, 1'b0, 8'hA3); chk_flags("fill3", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        op(1'b1, 1'b0, 8'hA4); chk_flags("fill4", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("fill.valid", valid_out, 1'b0);

        // Overflow: rejected write, contents preserved.
        op(1'b1, 1'b0, 8'hA5);
        chk("ovf.flag", overflow, 1'b1);
        chk("ovf.count", fifo_count, 3'd4);
        chk("ovf.udf", underflow, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_d = 8'hA1 + 8'(i);
            op(1'b0, 1'b1, 8'h00);
            chk("drain1.data", data_out, exp_d);
            chk("drain1.valid", valid_out, 1'b1);
            chk("drain1.count", fifo_count, 3'(3 - i));
        end
        chk_flags("drain1.end", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        op(1'b0, 1'b0, 8'h00);
        chk("idle.valid", valid_out, 1'b0);
        chk("idle.hold", data_out, 8'hA4);
        chk("ovf.sticky", overflow, 1'b1);

        // Underflow.
        op(1'b0, 1'b1, 8'h00);
        chk("udf.flag", underflow, 1'b1);
        chk("udf.valid", valid_out, 1'b0);
        chk("udf.hold", data_out, 8'hA4);
        chk("udf.count", fifo_count, 3'd0);

        // Read+write while full.
        for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 8'h10 + 8'(i));
        chk("rwfull.pre", fifo_count, 3'd4);
        op(1'b1, 1'b1, 8'h20);
        chk("rwfull.data", data_out, 8'h10);
        chk("rwfull.valid", valid_out, 1'b1);
        chk("rwfull.count", fifo_count, 3'd4);
        chk("rwfull.ovf", overflow, 1'b1);
        for (int i = 0; i < 4; i++) begin
            exp_d = (i == 3) ? 8'h20 : 8'h11 + 8'(i);
            op(1'b0, 1'b1, 8'h00);
            chk("drain2.data", data_out, exp_d);
        end
        chk("drain2.empty", empty, 1'b1);

        // Mid-stream async reset clears errors and contents.
        op(1'b1, 1'b0, 8'h77);
        op(1'b1, 1'b0, 8'h78);
        pulse_reset();
        chk_flags("postrst", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Read+write while empty: no bypass.
        op(1'b1, 1'b1, 8'h55);
        chk("rwempty.count", fifo_count, 3'd1);
        chk("rwempty.valid", valid_out, 1'b0);
        chk("rwempty.udf", underflow, 1'b1);
        chk("rwempty.ovf", overflow, 1'b0);
        op(1'b0, 1'b1, 8'h00);
        chk("rwempty.data", data_out, 8'h55);
        chk("rwempty.valid2", valid_out, 1'b1);

        // Wrap: interleaved push/pop, pointers wrap repeatedly.
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            op(1'b1, 1'b0, 8'h30 + 8'(i));
            chk("wrap.cnt1", fifo_count, 3'd1);
            op(1'b0, 1'b1, 8'h00);
            chk("wrap.data", data_out, 8'h30 + 8'(i));
            chk("wrap.cnt0", fifo_count, 3'd0);
        end
        chk("wrap.ovf", overflow, 1'b0);
        chk("wrap.udf", underflow, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
